// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: synchronizes the start/target buttons, runs a
// tick prescaler while a game is in progress, spawns lamps pseudo-randomly,
// ages lit lamps into misses, and keeps a saturating hit-minus-miss score.
module mole_scheduler #(
    parameter int          TICK_CYCLES     = 100000,
    parameter int          LAMP_ON_TICKS   = 1000,
    parameter int          SPAWN_GAP_TICKS = 500,
    parameter int          GAME_TICKS      = 30000,
    parameter int          MAX_LIT         = 2,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_n,
    input  logic [3:0]  btn_n,
    output logic [3:0]  lamp,
    output logic        ingame,
    output logic [15:0] score,
    output logic [15:0] ticks_left,
    output logic        game_over
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int AW = (LAMP_ON_TICKS > 1) ? $clog2(LAMP_ON_TICKS) : 1;
    localparam int GW = (SPAWN_GAP_TICKS > 0) ? $clog2(SPAWN_GAP_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [AW-1:0] AGE_LAST   = AW'(LAMP_ON_TICKS - 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(SPAWN_GAP_TICKS);
    localparam logic [15:0]   GAME_INIT  = 16'(GAME_TICKS);
    localparam logic [2:0]    MAX_LIT_V  = 3'(MAX_LIT);
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0]   LFSR_TAPS  = 16'hB400;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [GW-1:0] gap_reg, gap_next;
    logic [15:0]   score_reg, score_next;
    logic [15:0]   ticks_reg, ticks_next;
    logic [15:0]   lfsr_reg, lfsr_next;
    logic [3:0]    lit_reg, lit_next;
    logic          game_over_reg, game_over_next;

    logic [4:0]    sync1_reg, sync2_reg, sync3_reg;
    logic [4:0]    press;
    logic          press_start;
    logic [3:0]    press_btn;

    logic          in_play, tick, last_tick, spawn_ok;
    logic [3:0]    hit, expire, miss, spawn_vec;
    logic [2:0]    hit_cnt, miss_cnt, lit_cnt;
    logic [17:0]   score_sum;
    logic [15:0]   score_sat;
    logic [1:0]    idx;

    // Two-flop synchronizers plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
            sync3_reg <= '1;
        end else begin
            sync1_reg <= {start_n, btn_n};
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    assign press       = sync3_reg & ~sync2_reg;
    assign press_start = press[4];
    assign press_btn   = press[3:0];

    assign in_play   = (state_reg == PLAY);
    assign tick      = in_play && (presc_reg == PRESC_LAST);
    assign last_tick = tick && (ticks_reg <= 16'd1);

    // Per-lamp hit/expiry decode and age counter
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lamp
            logic [AW-1:0] age_reg;

            assign hit[gi]    = in_play & press_btn[gi] & lit_reg[gi];
            assign expire[gi] = tick & lit_reg[gi] & (age_reg == AGE_LAST);
            assign miss[gi]   = expire[gi] & ~hit[gi];

            // Age restarts at zero whenever the lamp is dark or freshly spawned
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    age_reg <= '0;
                end else if (!lit_next[gi] || !lit_reg[gi]) begin
                    age_reg <= '0;
                end else if (tick) begin
                    age_reg <= age_reg + AW'(1);
                end
            end
        end
    endgenerate

    assign hit_cnt  = {2'b00, hit[0]} + {2'b00, hit[1]} + {2'b00, hit[2]} + {2'b00, hit[3]};
    assign miss_cnt = {2'b00, miss[0]} + {2'b00, miss[1]} + {2'b00, miss[2]} + {2'b00, miss[3]};
    assign lit_cnt  = {2'b00, lit_reg[0]} + {2'b00, lit_reg[1]} + {2'b00, lit_reg[2]} + {2'b00, lit_reg[3]};

    // 18-bit sum: bit 17 set means the result went negative, bit 16 means overflow
    assign score_sum = {2'b00, score_reg} + {15'd0, hit_cnt} - {15'd0, miss_cnt};
    assign score_sat = score_sum[17] ? 16'h0000 :
                       (score_sum[16] ? 16'hFFFF : score_sum[15:0]);

    assign spawn_ok = tick && !last_tick && (gap_reg == '0) && (lit_cnt < MAX_LIT_V);

    // Pick the first dark lamp scanning upward from the LFSR's low bits
    always_comb begin
        spawn_vec = '0;
        idx       = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = lfsr_reg[1:0] + 2'(k);
            if (!lit_reg[idx]) begin
                spawn_vec     = '0;
                spawn_vec[idx] = 1'b1;
            end
        end
    end

    assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);

    // Next-state, prescaler, tick counter, spawn gap, score and lit-vector update
    always_comb begin
        state_next     = state_reg;
        presc_next     = presc_reg;
        gap_next       = gap_reg;
        score_next     = score_reg;
        ticks_next     = ticks_reg;
        lit_next       = '0;
        game_over_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (press_start || press_btn[0]) begin
                    state_next = PLAY;
                    score_next = '0;
                    ticks_next = GAME_INIT;
                    gap_next   = '0;
                    presc_next = '0;
                end
            end
            PLAY: begin
                presc_next = tick ? '0 : presc_reg + PW'(1);
                score_next = score_sat;
                lit_next   = (lit_reg & ~hit & ~expire) | (spawn_ok ? spawn_vec : 4'b0000);
                if (tick) begin
                    if (last_tick) begin
                        state_next     = OVER;
                        ticks_next     = '0;
                        lit_next       = '0;
                        game_over_next = 1'b1;
                    end else begin
                        ticks_next = ticks_reg - 16'd1;
                        if (spawn_ok) begin
                            gap_next = GAP_RELOAD;
                        end else if (gap_reg != '0) begin
                            gap_next = gap_reg - GW'(1);
                        end
                    end
                end
            end
            OVER: begin
                if (press_start) begin
                    state_next = PLAY;
                    score_next = '0;
                    ticks_next = GAME_INIT;
                    gap_next   = '0;
                    presc_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Game state registers; the LFSR free-runs in every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            presc_reg     <= '0;
            gap_reg       <= '0;
            score_reg     <= '0;
            ticks_reg     <= '0;
            lfsr_reg      <= LFSR_SEED;
            lit_reg       <= '0;
            game_over_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            presc_reg     <= presc_next;
            gap_reg       <= gap_next;
            score_reg     <= score_next;
            ticks_reg     <= ticks_next;
            lfsr_reg      <= lfsr_next;
            lit_reg       <= lit_next;
            game_over_reg <= game_over_next;
        end
    end

    assign lamp       = lit_reg;
    assign ingame     = in_play;
    assign score      = score_reg;
    assign ticks_left = ticks_reg;
    assign game_over  = game_over_reg;

endmodule

// File: tb/tb_mole_scheduler.sv
// Randomized bench for mole_scheduler: a cycle-level game model predicts the
// outputs after every rising edge; a monitor compares them on the falling edge.
module tb_mole_scheduler;

    localparam int TC = 4;
    localparam int LT = 5;
    localparam int SG = 3;
    localparam int GT = 40;
    localparam int ML = 2;

    localparam int S_IDLE = 0;
    localparam int S_PLAY = 1;
    localparam int S_OVER = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_n = 1'b1;
    logic [3:0]  btn_n = 4'hF;
    logic [3:0]  lamp;
    logic        ingame;
    logic [15:0] score;
    logic [15:0] ticks_left;
    logic        game_over;
    bit          clk_run = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0]  lamp;
        logic        ingame;
        logic [15:0] score;
        logic [15:0] ticks;
        logic        go;
    } obs_t;

    obs_t exp_q[$];

    // Reference model state
    int         m_state, m_score, m_ticks, m_presc, m_gap;
    int         m_age[4];
    bit [3:0]   m_lit;
    bit         m_go;
    bit [15:0]  m_lfsr;
    bit [4:0]   m_hist[4];

    mole_scheduler #(
        .TICK_CYCLES(TC), .LAMP_ON_TICKS(LT), .SPAWN_GAP_TICKS(SG),
        .GAME_TICKS(GT), .MAX_LIT(ML), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start_n(start_n), .btn_n(btn_n),
        .lamp(lamp), .ingame(ingame), .score(score),
        .ticks_left(ticks_left), .game_over(game_over)
    );

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = S_IDLE; m_score = 0; m_ticks = 0; m_presc = 0; m_gap = 0;
        m_lit = '0; m_go = 1'b0; m_lfsr = 16'hACE1;
        for (int i = 0; i < 4; i++) begin
            m_age[i] = 0;
            m_hist[i] = 5'h1F;
        end
    endtask

    task automatic new_game();
        m_state = S_PLAY; m_score = 0; m_ticks = GT; m_gap = 0; m_presc = 0;
        m_lit = '0;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
    endtask

    // One clock of the game rules; raw = {start_n, btn_n} seen at this edge
    task automatic model_step(input bit [4:0] raw);
        bit [4:0] pr;
        bit [3:0] old_lit;
        bit       tck, found;
        int       hits, misses, base, j;
        m_hist[3] = m_hist[2];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = raw;
        pr = m_hist[3] & ~m_hist[2];
        m_go = 1'b0;
        if (m_state == S_IDLE) begin
            if (pr[4] || pr[0]) new_game();
        end else if (m_state == S_OVER) begin
            if (pr[4]) new_game();
        end else begin
            tck = (m_presc == TC - 1);
            old_lit = m_lit;
            hits = 0;
            misses = 0;
            for (int i = 0; i < 4; i++) begin
                if (old_lit[i]) begin
                    if (pr[i]) begin
                        hits++; m_lit[i] = 1'b0; m_age[i] = 0;
                    end else if (tck) begin
                        m_age[i]++;
                        if (m_age[i] == LT) begin
                            misses++; m_lit[i] = 1'b0; m_age[i] = 0;
                        end
                    end
                end
            end
            m_score = m_score + hits - misses;
            if (m_score < 0) m_score = 0;
            if (m_score > 65535) m_score = 65535;
            if (tck) begin
                m_presc = 0;
                if (m_ticks <= 1) begin
                    m_state = S_OVER; m_ticks = 0; m_lit = '0; m_go = 1'b1;
                    for (int i = 0; i < 4; i++) m_age[i] = 0;
                end else begin
                    m_ticks--;
                    if (m_gap == 0 && $countones(old_lit) < ML) begin
                        base = int'(m_lfsr % 4);
                        found = 1'b0;
                        for (int k = 0; k < 4; k++) begin
                            j = (base + k) % 4;
                            if (!found && !old_lit[j]) begin
                                found = 1'b1; m_lit[j] = 1'b1; m_age[j] = 0;
                            end
                        end
                        m_gap = SG;
                    end else if (m_gap > 0) begin
                        m_gap--;
                    end
                end
            end else begin
                m_presc++;
            end
        end
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    // Predict outputs after every rising edge
    always @(posedge clk) begin
        obs_t e;
        if (!reset) model_reset();
        else model_step({start_n, btn_n});
        e.lamp = m_lit; e.ingame = (m_state == S_PLAY); e.score = 16'(m_score);
        e.ticks = 16'(m_ticks); e.go = m_go;
        exp_q.push_back(e);
    end

    // Compare DUT against the oldest prediction on the falling edge
    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = obs_t'({lamp, ingame, score, ticks_left, game_over});
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t got lamp=%h ingame=%b score=%0d ticks_left=%0d game_over=%b want lamp=%h ingame=%b score=%0d ticks_left=%0d game_over=%b",
                         $time, a.lamp, a.ingame, a.score, a.ticks, a.go, e.lamp, e.ingame, e.score, e.ticks, e.go);
            end else begin
                $display("vec %0d t=%0t lamp=%h ingame=%b score=%0d ticks_left=%0d game_over=%b",
                         vectors, $time, a.lamp, a.ingame, a.score, a.ticks, a.go);
            end
            vectors++;
            if ($countones(lamp) > ML) begin
                miscompares++;
                $display("FAIL max_lit t=%0t got %0d lit, limit %0d", $time, $countones(lamp), ML);
            end
        end
    end

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, act, req);
        end else begin
            $display("chk %s ok value=%h", name, act);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s got timeout want state change", name);
    endtask

    task automatic rand_stim();
        if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 3))
                0:       btn_n = 4'hF;
                1, 2:    btn_n = ~(m_lit & 4'($urandom));
                default: btn_n = 4'($urandom);
            endcase
        end
        start_n = (m_ticks > 4 && $urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
    endtask

    // Wait for the model to enter PLAY, then drive until the game ends
    task automatic play_game(input bit rnd, input int max_cycles);
        int n;
        n = 0;
        while (m_state != S_PLAY && n < 12) begin
            @(negedge clk); n++;
        end
        if (m_state != S_PLAY) timeout("game_start");
        n = 0;
        while (m_state == S_PLAY && n < max_cycles) begin
            @(negedge clk);
            if (rnd) rand_stim();
            n++;
        end
        btn_n = 4'hF;
        start_n = 1'b1;
        if (m_state != S_OVER) timeout("game_end");
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", {lamp, ingame, score, ticks_left, game_over}, 38'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Game 1: start held 8 cycles, no target presses at all
        start_n = 1'b0;
        repeat (8) @(negedge clk);
        start_n = 1'b1;
        play_game(1'b0, 300);
        check("idle_game_score", {22'd0, score}, 38'd0);

        // OVER: target presses must be ignored
        repeat (30) begin
            @(negedge clk);
            btn_n = 4'($urandom);
        end
        btn_n = 4'hF;
        repeat (4) @(negedge clk);

        // Game 2: random presses throughout
        start_n = 1'b0;
        @(negedge clk);
        start_n = 1'b1;
        play_game(1'b1, 300);
        repeat (4) @(negedge clk);

        // Game 3: random presses, then asynchronous reset with the clock stopped
        start_n = 1'b0;
        @(negedge clk);
        start_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            rand_stim();
        end
        btn_n = 4'hF;
        start_n = 1'b1;
        n = 0;
        while (m_lit == '0 && n < 100) begin
            @(negedge clk); n++;
        end
        if (m_lit == '0) timeout("lamps_lit_before_reset");
        clk_run = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {lamp, ingame, score, ticks_left, game_over}, 38'd0);
        model_reset();
        exp_q.delete();
        #3;
        reset = 1'b1;
        #2;
        clk_run = 1'b1;
        repeat (4) @(negedge clk);

        // Game 4: started by target button 0 from IDLE
        btn_n = 4'hE;
        @(negedge clk);
        btn_n = 4'hF;
        play_game(1'b1, 300);
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
